multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multicycle main controller for the RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback states. Per state it drives the ALUOp code consumed by the ALU control decoder, plus the datapath mux selects, register/PC write enables and the memory request strobes. It sits between the instruction register (opcode/funct3 inputs) and the shared datapath, and replaces hard-wired single-cycle control.

## Interface
Parameters:
- `MEM_WAIT_MAX`, 0: if nonzero, a memory request unanswered after this many cycles raises `o_Illegal`. 0 disables the watchdog.

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_Opcode`  in  7  instruction register [6:0]
- `i_Funct3`  in  3  instruction register [14:12]
- `i_Zero`  in  1  ALU zero flag, valid in BRANCH
- `i_MemReady`  in  1  memory completes the current request this cycle
- `o_ALUOp`  out  3  000 add (I_L), 001 sub (B), 010 R, 011 I, 100 LUI; 101 (AUIPC) is reserved and never driven
- `o_ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1 register
- `o_ALUSrcB`  out  2  00 rs2 register, 01 constant 4, 10 immediate
- `o_MemToReg`  out  2  00 ALUOut, 01 MDR, 10 PC
- `o_PCSource`  out  1  0 ALU result, 1 ALUOut
- `o_IorD`  out  1  memory address: 0 PC, 1 ALUOut
- `o_PCWrite`, `o_IRWrite`, `o_RegWrite`, `o_MemRead`, `o_MemWrite`  out  1 each  strobes
- `o_Illegal`  out  1  sticky fault flag
- `o_State`  out  4  current state, for debug

## Operation
- Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. BRANCH is legal only with funct3 000 (BEQ) or 001 (BNE).
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=000. When i_MemReady=1: IRWrite=1, PCWrite=1, PCSource=0, and go to DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=000, so ALUOut <= OldPC+imm. Next state by opcode:
  - OP → EXEC_R
  - OP-IMM → EXEC_I
  - LOAD/STORE → ADDR
  - BRANCH → BRANCH
  - JAL → JUMP
  - JALR → EXEC_JALR
  - LUI → EXEC_LUI
  - AUIPC → WB_ALU
  - illegal → see Configuration
- EXEC_R: A=10, B=00, ALUOp=010. Then WB_ALU.
- EXEC_I: A=10, B=10, ALUOp=011. Then WB_ALU.
- EXEC_LUI: B=10, ALUOp=100. Then WB_ALU.
- ADDR: A=10, B=10, ALUOp=000. Then MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD: MemRead=1, IorD=1. On i_MemReady go to WB_MEM.
- WB_MEM: RegWrite=1, MemToReg=01. Then FETCH.
- MEM_WR: MemWrite=1, IorD=1. On i_MemReady go to FETCH.
- WB_ALU: RegWrite=1, MemToReg=00. Then FETCH.
- BRANCH: A=10, B=00, ALUOp=001, PCSource=1. PCWrite = i_Zero for BEQ, !i_Zero for BNE. Then FETCH.
- EXEC_JALR: A=10, B=10, ALUOp=000. Then JUMP.
- JUMP: PCWrite=1, PCSource=1, RegWrite=1, MemToReg=10 (rd <= PC, which already holds the link value). Then FETCH.
- TRAP: all strobes 0, o_Illegal=1. Exit only by reset.

## Timing
- Outputs are decoded from the state register. Exceptions: the FETCH IRWrite/PCWrite and the BRANCH PCWrite are qualified combinationally by i_MemReady and i_Zero respectively.
- While i_rst=1 every output is forced to 0 and the state is FETCH. An assertion mid-instruction aborts it with no partial register or PC write after the reset edge.
- i_MemReady high in the first FETCH, MEM_RD or MEM_WR cycle gives a one-cycle access. Each low cycle adds exactly one cycle.
- Zero-wait latency, from the first FETCH cycle to the next FETCH:
  - BRANCH: 3
  - AUIPC, JAL: 3
  - OP, OP-IMM, LUI, STORE, JALR: 4
  - LOAD: 5
- i_MemReady is ignored outside the memory states. i_Zero is ignored outside BRANCH.
- Watchdog (MEM_WAIT_MAX>0): the counter clears on entry to each memory state. Reaching MEM_WAIT_MAX without i_MemReady sets o_Illegal and goes to TRAP.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: an illegal opcode or branch funct3 in DECODE goes to TRAP and o_Illegal stays high until reset.
- Macro undefined: the illegal instruction is a NOP. DECODE goes to FETCH, PC keeps the +4 from fetch, and o_Illegal stays 0. The watchdog still traps.

## Structure
- `defines/CONTROL_FSM.vh` holds:
  - the state encodings (4-bit)
  - the ALUSrcA, ALUSrcB, MemToReg and PCSource codes
  - the ALUOp codes, shared with the ALU control decoder
- Opcode values come from the existing opcode defines.
- One sub-module, `opcode_class_dec`: combinational. It maps i_Opcode/i_Funct3 to a one-hot instruction class plus an illegal bit, and DECODE uses it for its next-state choice.

## Test plan
- Reset mid-MEM_WR with MemWrite=1 → all outputs 0 immediately; after release, state=FETCH and MemRead=1.
- R-type 0110011 with i_MemReady tied to 1 → four states FETCH, DECODE, EXEC_R, WB_ALU; ALUOp=010 in EXEC_R; RegWrite=1 for exactly one cycle.
- LOAD 0000011 with i_MemReady low for 2 cycles in MEM_RD → MEM_RD lasts 3 cycles; total 7 cycles; MemToReg=01 in WB_MEM.
- BEQ (funct3 000): i_Zero=1 → PCWrite=1 with PCSource=1. i_Zero=0 → PCWrite=0. BNE (funct3 001) → inverse.
- JAL 1101111 → 3 cycles; JUMP asserts PCWrite, RegWrite and MemToReg=10 together.
- Opcode 1111111 → with the macro: TRAP, o_Illegal=1, no strobes thereafter. Without the macro: back to FETCH after DECODE, no RegWrite.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I main controller: states, datapath
// select codes, ALUOp codes (shared with the ALU control decoder) and opcodes.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_EXEC_I    = 4'd3,
      S_EXEC_LUI  = 4'd4,
      S_ADDR      = 4'd5,
      S_MEM_RD    = 4'd6,
      S_WB_MEM    = 4'd7,
      S_MEM_WR    = 4'd8,
      S_WB_ALU    = 4'd9,
      S_BRANCH    = 4'd10,
      S_EXEC_JALR = 4'd11,
      S_JUMP      = 4'd12,
      S_TRAP      = 4'd13
   } state_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // 3'b101 is held back for AUIPC and is never driven by this controller.
   localparam logic [2:0] ALUOP_ADD = 3'b000;
   localparam logic [2:0] ALUOP_SUB = 3'b001;
   localparam logic [2:0] ALUOP_R   = 3'b010;
   localparam logic [2:0] ALUOP_I   = 3'b011;
   localparam logic [2:0] ALUOP_LUI = 3'b100;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;
   localparam logic       PCSRC_ALU    = 1'b0;
   localparam logic       PCSRC_ALUOUT = 1'b1;

   localparam int CLS_OP     = 0;
   localparam int CLS_OPIMM  = 1;
   localparam int CLS_LOAD   = 2;
   localparam int CLS_STORE  = 3;
   localparam int CLS_BRANCH = 4;
   localparam int CLS_JAL    = 5;
   localparam int CLS_JALR   = 6;
   localparam int CLS_LUI    = 7;
   localparam int CLS_AUIPC  = 8;
   localparam int CLS_W      = 9;

   // pc_write_fetch/ir_write_fetch/pc_write_br still need i_MemReady or i_Zero.
   typedef struct packed {
      logic [2:0] alu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] mem_to_reg;
      logic       pc_source;
      logic       iord;
      logic       pc_write;
      logic       pc_write_fetch;
      logic       pc_write_br;
      logic       ir_write_fetch;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
   } ctrl_t;

   function automatic ctrl_t ctrl_for_state(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read = 1'b1;  c.alu_src_a = SRCA_PC;  c.alu_src_b = SRCB_FOUR;
            c.alu_op = ALUOP_ADD;  c.pc_source = PCSRC_ALU;
            c.ir_write_fetch = 1'b1;  c.pc_write_fetch = 1'b1;
         end
         S_DECODE:    begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_ADD; end
         S_EXEC_R:    begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2; c.alu_op = ALUOP_R; end
         S_EXEC_I:    begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_I; end
         S_EXEC_LUI:  begin c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_LUI; end
         S_ADDR,
         S_EXEC_JALR: begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_ADD; end
         S_MEM_RD:    begin c.mem_read = 1'b1; c.iord = 1'b1; end
         S_MEM_WR:    begin c.mem_write = 1'b1; c.iord = 1'b1; end
         S_WB_MEM:    begin c.reg_write = 1'b1; c.mem_to_reg = M2R_MDR; end
         S_WB_ALU:    begin c.reg_write = 1'b1; c.mem_to_reg = M2R_ALUOUT; end
         S_BRANCH: begin
            c.alu_src_a = SRCA_RS1;  c.alu_src_b = SRCB_RS2;  c.alu_op = ALUOP_SUB;
            c.pc_source = PCSRC_ALUOUT;  c.pc_write_br = 1'b1;
         end
         // PC already holds the link value, so rd takes PC before the jump lands.
         S_JUMP: begin
            c.pc_write = 1'b1;  c.pc_source = PCSRC_ALUOUT;
            c.reg_write = 1'b1;  c.mem_to_reg = M2R_PC;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_opcode_class_dec.sv
// Combinational instruction classifier: one-hot class plus illegal bit from
// the opcode and funct3 fields of the instruction register.
module opcode_class_dec
   import multicycle_control_fsm_pkg::*;
(
   input  logic [6:0]       i_Opcode,
   input  logic [2:0]       i_Funct3,
   output logic [CLS_W-1:0] o_Class,
   output logic             o_Illegal
);

   always_comb begin
      o_Class   = '0;
      o_Illegal = 1'b0;
      case (i_Opcode)
         OPC_OP:    o_Class[CLS_OP]    = 1'b1;
         OPC_OPIMM: o_Class[CLS_OPIMM] = 1'b1;
         OPC_LOAD:  o_Class[CLS_LOAD]  = 1'b1;
         OPC_STORE: o_Class[CLS_STORE] = 1'b1;
         OPC_JAL:   o_Class[CLS_JAL]   = 1'b1;
         OPC_JALR:  o_Class[CLS_JALR]  = 1'b1;
         OPC_LUI:   o_Class[CLS_LUI]   = 1'b1;
         OPC_AUIPC: o_Class[CLS_AUIPC] = 1'b1;
         OPC_BRANCH: begin
            if (i_Funct3 == F3_BEQ || i_Funct3 == F3_BNE) o_Class[CLS_BRANCH] = 1'b1;
            else                                          o_Illegal = 1'b1;
         end
         default:   o_Illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main controller. Define CTRL_ILLEGAL_TRAP_EN to trap on
// illegal instructions; otherwise they retire as NOPs.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 0
)
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_Opcode,
   input  logic [2:0] i_Funct3,
   input  logic       i_Zero,
   input  logic       i_MemReady,
   output logic [2:0] o_ALUOp,
   output logic [1:0] o_ALUSrcA,
   output logic [1:0] o_ALUSrcB,
   output logic [1:0] o_MemToReg,
   output logic       o_PCSource,
   output logic       o_IorD,
   output logic       o_PCWrite,
   output logic       o_IRWrite,
   output logic       o_RegWrite,
   output logic       o_MemRead,
   output logic       o_MemWrite,
   output logic       o_Illegal,
   output logic [3:0] o_State
);

   localparam bit WD_EN = (MEM_WAIT_MAX > 0);
   localparam int WCW   = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

   state_e           state, next_state;
   ctrl_t            ctrl_q;
   logic             illegal_q;
   logic [WCW-1:0]   wait_cnt;
   logic [CLS_W-1:0] cls;
   logic             cls_illegal;
   logic             in_mem, wd_expire, br_take;

   opcode_class_dec u_dec (
      .i_Opcode  (i_Opcode),
      .i_Funct3  (i_Funct3),
      .o_Class   (cls),
      .o_Illegal (cls_illegal)
   );

   assign in_mem    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign wd_expire = WD_EN && in_mem && !i_MemReady && (wait_cnt == WAIT_LAST);
   assign br_take   = (i_Funct3 == F3_BNE) ? !i_Zero : i_Zero;

   always_comb begin
      next_state = state;
      case (state)
         S_FETCH: if (i_MemReady) next_state = S_DECODE;
         S_DECODE: begin
            if (cls_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               next_state = S_TRAP;
`else
               next_state = S_FETCH;
`endif
            end
            else if (cls[CLS_OP])                     next_state = S_EXEC_R;
            else if (cls[CLS_OPIMM])                  next_state = S_EXEC_I;
            else if (cls[CLS_LOAD] || cls[CLS_STORE]) next_state = S_ADDR;
            else if (cls[CLS_BRANCH])                 next_state = S_BRANCH;
            else if (cls[CLS_JAL])                    next_state = S_JUMP;
            else if (cls[CLS_JALR])                   next_state = S_EXEC_JALR;
            else if (cls[CLS_LUI])                    next_state = S_EXEC_LUI;
            else if (cls[CLS_AUIPC])                  next_state = S_WB_ALU;
            else                                      next_state = S_FETCH;
         end
         S_EXEC_R, S_EXEC_I, S_EXEC_LUI: next_state = S_WB_ALU;
         S_ADDR:      next_state = cls[CLS_STORE] ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:    if (i_MemReady) next_state = S_WB_MEM;
         S_MEM_WR:    if (i_MemReady) next_state = S_FETCH;
         S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: next_state = S_FETCH;
         S_EXEC_JALR: next_state = S_JUMP;
         S_TRAP:      next_state = S_TRAP;
         default:     next_state = S_FETCH;
      endcase
      if (wd_expire) next_state = S_TRAP;
   end

   // The wait counter restarts on every state change, so each memory state gets a fresh budget.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_FETCH;
         ctrl_q    <= ctrl_for_state(S_FETCH);
         illegal_q <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state  <= next_state;
         ctrl_q <= ctrl_for_state(next_state);
         if (next_state == S_TRAP) illegal_q <= 1'b1;
         if (next_state != state)             wait_cnt <= '0;
         else if (in_mem && !i_MemReady)      wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      o_ALUOp    = '0;
      o_ALUSrcA  = '0;
      o_ALUSrcB  = '0;
      o_MemToReg = '0;
      o_PCSource = 1'b0;
      o_IorD     = 1'b0;
      o_PCWrite  = 1'b0;
      o_IRWrite  = 1'b0;
      o_RegWrite = 1'b0;
      o_MemRead  = 1'b0;
      o_MemWrite = 1'b0;
      o_Illegal  = 1'b0;
      o_State    = '0;
      if (!i_rst) begin
         o_ALUOp    = ctrl_q.alu_op;
         o_ALUSrcA  = ctrl_q.alu_src_a;
         o_ALUSrcB  = ctrl_q.alu_src_b;
         o_MemToReg = ctrl_q.mem_to_reg;
         o_PCSource = ctrl_q.pc_source;
         o_IorD     = ctrl_q.iord;
         o_PCWrite  = ctrl_q.pc_write | (ctrl_q.pc_write_fetch & i_MemReady)
                    | (ctrl_q.pc_write_br & br_take);
         o_IRWrite  = ctrl_q.ir_write_fetch & i_MemReady;
         o_RegWrite = ctrl_q.reg_write;
         o_MemRead  = ctrl_q.mem_read;
         o_MemWrite = ctrl_q.mem_write;
         o_Illegal  = illegal_q;
         o_State    = state;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm; follows
// CTRL_ILLEGAL_TRAP_EN for the illegal-instruction expectations.
module tb_multicycle_control_fsm;

   localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1, ST_EXEC_R = 4'd2;
   localparam logic [3:0] ST_ADDR  = 4'd5,  ST_MEM_RD = 4'd6, ST_WB_MEM = 4'd7;
   localparam logic [3:0] ST_MEM_WR = 4'd8, ST_WB_ALU = 4'd9, ST_BRANCH = 4'd10;
   localparam logic [3:0] ST_JUMP  = 4'd12, ST_TRAP = 4'd13;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [6:0] i_Opcode = 7'b0110011;
   logic [2:0] i_Funct3 = 3'b000;
   logic       i_Zero = 1'b0;
   logic       i_MemReady = 1'b1;
   logic [2:0] o_ALUOp;
   logic [1:0] o_ALUSrcA, o_ALUSrcB, o_MemToReg;
   logic       o_PCSource, o_IorD, o_PCWrite, o_IRWrite, o_RegWrite;
   logic       o_MemRead, o_MemWrite, o_Illegal;
   logic [3:0] o_State;

   int checks = 0;
   int failures = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_st;

   logic [3:0] s_state;
   logic [2:0] s_alu_op;
   logic [1:0] s_m2r;
   logic       s_pcsrc, s_iord, s_pcw, s_irw, s_rw, s_mr, s_mw, s_ill;

   wire [20:0] all_outs = {o_ALUOp, o_ALUSrcA, o_ALUSrcB, o_MemToReg, o_PCSource, o_IorD,
                           o_PCWrite, o_IRWrite, o_RegWrite, o_MemRead, o_MemWrite,
                           o_Illegal, o_State};

   multicycle_control_fsm dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_Opcode(i_Opcode), .i_Funct3(i_Funct3),
      .i_Zero(i_Zero), .i_MemReady(i_MemReady), .o_ALUOp(o_ALUOp),
      .o_ALUSrcA(o_ALUSrcA), .o_ALUSrcB(o_ALUSrcB), .o_MemToReg(o_MemToReg),
      .o_PCSource(o_PCSource), .o_IorD(o_IorD), .o_PCWrite(o_PCWrite),
      .o_IRWrite(o_IRWrite), .o_RegWrite(o_RegWrite), .o_MemRead(o_MemRead),
      .o_MemWrite(o_MemWrite), .o_Illegal(o_Illegal), .o_State(o_State)
   );

   always #5 i_clk = ~i_clk;

   // Drive one cycle's inputs, snapshot outputs at the falling edge, step past the rising edge.
   task automatic cycle(input logic rdy, input logic zr);
      i_MemReady = rdy;
      i_Zero     = zr;
      @(negedge i_clk);
      s_state = o_State;  s_alu_op = o_ALUOp;  s_m2r = o_MemToReg;
      s_pcsrc = o_PCSource;  s_iord = o_IorD;  s_pcw = o_PCWrite;  s_irw = o_IRWrite;
      s_rw = o_RegWrite;  s_mr = o_MemRead;  s_mw = o_MemWrite;  s_ill = o_Illegal;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      @(negedge i_clk);
      checks++;
      if (all_outs !== 21'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0", all_outs); end
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      cycle(1'b0, 1'b0);
      checks++;
      if (s_state !== ST_FETCH) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", s_state, ST_FETCH); end
      checks++;
      if ({s_mr, s_iord, s_irw, s_pcw} !== 4'b1000) begin
         failures++; $display("FAIL fetch_wait got mr/iord/irw/pcw=%b exp=1000", {s_mr, s_iord, s_irw, s_pcw});
      end
   endtask

   task automatic test_r_type();
      int rw_cnt;
      rw_cnt = 0;
      i_Opcode = 7'b0110011;  i_Funct3 = 3'b000;
      exp_q = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_WB_ALU, ST_FETCH};
      for (int i = 0; i < 5; i++) begin
         cycle(i < 4, 1'b0);
         exp_st = exp_q.pop_front();
         checks++;
         if (s_state !== exp_st) begin failures++; $display("FAIL r_state[%0d] got=%0d exp=%0d", i, s_state, exp_st); end
         if (i == 0) begin
            checks++;
            if ({s_irw, s_pcw, s_pcsrc} !== 3'b110) begin failures++; $display("FAIL r_fetch got=%b exp=110", {s_irw, s_pcw, s_pcsrc}); end
         end
         if (i == 2) begin
            checks++;
            if (s_alu_op !== 3'b010) begin failures++; $display("FAIL r_aluop got=%b exp=010", s_alu_op); end
         end
         rw_cnt += int'(s_rw);
      end
      checks++;
      if (rw_cnt !== 1) begin failures++; $display("FAIL r_regwrite_cycles got=%0d exp=1", rw_cnt); end
   endtask

   task automatic test_load_wait();
      logic [7:0] rdy_pat;
      rdy_pat = 8'b0110_0111;  // bit i = MemReady in cycle i
      i_Opcode = 7'b0000011;
      exp_q = '{ST_FETCH, ST_DECODE, ST_ADDR, ST_MEM_RD, ST_MEM_RD, ST_MEM_RD, ST_WB_MEM, ST_FETCH};
      for (int i = 0; i < 8; i++) begin
         cycle(rdy_pat[i], 1'b0);
         exp_st = exp_q.pop_front();
         checks++;
         if (s_state !== exp_st) begin failures++; $display("FAIL load_state[%0d] got=%0d exp=%0d", i, s_state, exp_st); end
         if (i == 3) begin
            checks++;
            if ({s_mr, s_iord, s_rw} !== 3'b110) begin failures++; $display("FAIL load_memrd got=%b exp=110", {s_mr, s_iord, s_rw}); end
         end
         if (i == 6) begin
            checks++;
            if ({s_rw, s_m2r} !== 3'b101) begin failures++; $display("FAIL load_wb got rw/m2r=%b exp=101", {s_rw, s_m2r}); end
         end
      end
   endtask

   task automatic test_branch();
      logic [2:0] f3_tab[4];
      logic       z_tab[4];
      logic       pcw_tab[4];
      f3_tab  = '{3'b000, 3'b000, 3'b001, 3'b001};
      z_tab   = '{1'b1, 1'b0, 1'b1, 1'b0};
      pcw_tab = '{1'b1, 1'b0, 1'b0, 1'b1};
      i_Opcode = 7'b1100011;
      for (int k = 0; k < 4; k++) begin
         i_Funct3 = f3_tab[k];
         cycle(1'b1, z_tab[k]);
         cycle(1'b1, z_tab[k]);
         cycle(1'b1, z_tab[k]);
         checks++;
         if (s_state !== ST_BRANCH) begin failures++; $display("FAIL br_state[%0d] got=%0d exp=%0d", k, s_state, ST_BRANCH); end
         checks++;
         if ({s_pcw, s_pcsrc, s_alu_op} !== {pcw_tab[k], 1'b1, 3'b001}) begin
            failures++; $display("FAIL br_ctrl[%0d] got pcw/pcsrc/aluop=%b exp=%b", k, {s_pcw, s_pcsrc, s_alu_op}, {pcw_tab[k], 4'b1001});
         end
         cycle(1'b0, z_tab[k]);
         checks++;
         if (s_state !== ST_FETCH) begin failures++; $display("FAIL br_return[%0d] got=%0d exp=%0d", k, s_state, ST_FETCH); end
      end
   endtask

   task automatic test_jal();
      i_Opcode = 7'b1101111;  i_Funct3 = 3'b000;
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      checks++;
      if (s_state !== ST_JUMP) begin failures++; $display("FAIL jal_state got=%0d exp=%0d", s_state, ST_JUMP); end
      checks++;
      if ({s_pcw, s_rw, s_m2r, s_pcsrc} !== 5'b11101) begin
         failures++; $display("FAIL jal_ctrl got pcw/rw/m2r/pcsrc=%b exp=11101", {s_pcw, s_rw, s_m2r, s_pcsrc});
      end
      cycle(1'b0, 1'b0);
      checks++;
      if (s_state !== ST_FETCH) begin failures++; $display("FAIL jal_return got=%0d exp=%0d", s_state, ST_FETCH); end
   endtask

   task automatic test_latency();
      logic [6:0] op_tab[6];
      int         lat_tab[6];
      int         n;
      op_tab  = '{7'b0010111, 7'b0010011, 7'b0110111, 7'b0100011, 7'b1100111, 7'b0000011};
      lat_tab = '{3, 4, 4, 4, 4, 5};
      for (int k = 0; k < 6; k++) begin
         i_Opcode = op_tab[k];  i_Funct3 = 3'b000;
         cycle(1'b1, 1'b0);
         n = 1;
         while (o_State !== ST_FETCH && n < 20) begin
            cycle(1'b1, 1'b0);
            n++;
         end
         i_MemReady = 1'b0;
         checks++;
         if (n !== lat_tab[k]) begin failures++; $display("FAIL latency[%b] got=%0d exp=%0d", op_tab[k], n, lat_tab[k]); end
      end
   endtask

   task automatic test_illegal();
      logic [6:0] op_tab[2];
      logic [2:0] f3_tab[2];
      op_tab = '{7'b1111111, 7'b1100011};
      f3_tab = '{3'b000, 3'b010};
      for (int k = 0; k < 2; k++) begin
         i_Opcode = op_tab[k];  i_Funct3 = f3_tab[k];
         cycle(1'b1, 1'b0);
         cycle(1'b1, 1'b0);
         checks++;
         if ({s_state, s_rw} !== {ST_DECODE, 1'b0}) begin failures++; $display("FAIL ill_decode[%0d] got=%0d/%b exp=%0d/0", k, s_state, s_rw, ST_DECODE); end
`ifdef CTRL_ILLEGAL_TRAP_EN
         for (int j = 0; j < 3; j++) begin
            cycle(1'b1, 1'b1);
            checks++;
            if ({s_state, s_ill, s_pcw, s_irw, s_rw, s_mr, s_mw} !== {ST_TRAP, 6'b100000}) begin
               failures++; $display("FAIL ill_trap[%0d.%0d] got st=%0d ill/strobes=%b exp st=%0d 100000", k, j, s_state,
                                    {s_ill, s_pcw, s_irw, s_rw, s_mr, s_mw}, ST_TRAP);
            end
         end
         i_rst = 1'b1;
         @(posedge i_clk); #1;
         i_rst = 1'b0;
         cycle(1'b0, 1'b0);
         checks++;
         if ({s_state, s_ill} !== {ST_FETCH, 1'b0}) begin failures++; $display("FAIL ill_reset_exit[%0d] got=%0d/%b exp=%0d/0", k, s_state, s_ill, ST_FETCH); end
`else
         cycle(1'b0, 1'b0);
         checks++;
         if ({s_state, s_ill, s_rw} !== {ST_FETCH, 2'b00}) begin
            failures++; $display("FAIL ill_nop[%0d] got st=%0d ill/rw=%b exp st=%0d 00", k, s_state, {s_ill, s_rw}, ST_FETCH);
         end
`endif
      end
   endtask

   task automatic test_reset_mid_store();
      i_Opcode = 7'b0100011;  i_Funct3 = 3'b010;
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      checks++;
      if ({s_state, s_mw, s_iord} !== {ST_MEM_WR, 2'b11}) begin
         failures++; $display("FAIL store_memwr got st=%0d mw/iord=%b exp st=%0d 11", s_state, {s_mw, s_iord}, ST_MEM_WR);
      end
      #2 i_rst = 1'b1;
      #1;
      checks++;
      if (all_outs !== 21'd0) begin failures++; $display("FAIL midreset_async got=%h exp=0", all_outs); end
      @(posedge i_clk); #1;
      @(negedge i_clk);
      checks++;
      if (all_outs !== 21'd0) begin failures++; $display("FAIL midreset_held got=%h exp=0", all_outs); end
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      cycle(1'b0, 1'b0);
      checks++;
      if ({s_state, s_mr, s_mw, s_rw} !== {ST_FETCH, 3'b100}) begin
         failures++; $display("FAIL midreset_release got st=%0d mr/mw/rw=%b exp st=%0d 100", s_state, {s_mr, s_mw, s_rw}, ST_FETCH);
      end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_load_wait();
      test_branch();
      test_jal();
      test_latency();
      test_illegal();
      test_reset_mid_store();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout got=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
